ysyx_22041207_ifu_axi_rd: RTL

- Upstream neighbour of the instruction-fetch stage: an AXI4 read master serving the fetch stage's simple request/data handshake (valid/ready request, valid/ready data return).
- Converts one fetch request into a single-beat AXI4 AR/R transaction.
- Returns the read data right-aligned to the request address.
- Sits between the fetch stage and the memory/crossbar AXI port.

---
 rtl/ysyx_22041207_ifu_axi_rd_pkg.sv | 35 +++
 rtl/ysyx_22041207_ifu_axi_rd_align.sv | 23 ++
 rtl/ysyx_22041207_ifu_axi_rd.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_ifu_axi_rd_pkg.sv
// Shared AXI constants, FSM state encoding and the byte-lane mask to arsize decode
// for the IFU single-beat AXI4 read master.
package ysyx_22041207_ifu_axi_rd_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    RESP
  } state_e;

  typedef struct packed {
    logic       illegal;
    logic [2:0] arsize;
  } size_dec_t;

  // Only the four contiguous right-aligned lane masks map onto an AXI size.
  function automatic size_dec_t decode_size(input logic [7:0] mask);
    size_dec_t d;
    d.illegal = 1'b0;
    d.arsize  = 3'd0;
    case (mask)
      8'h01:   d.arsize = 3'd0;
      8'h03:   d.arsize = 3'd1;
      8'h0F:   d.arsize = 3'd2;
      8'hFF:   d.arsize = 3'd3;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ysyx_22041207_ifu_axi_rd_align.sv
// Right-aligns a 64-bit read beat to the byte offset of the request and
// zero-extends it to the access size.
module ysyx_22041207_rd_align (
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_arsize,
  output logic [63:0] o_data
);

  logic [63:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    case (i_arsize)
      3'd0:    o_data = {56'd0, w_shifted[7:0]};
      3'd1:    o_data = {48'd0, w_shifted[15:0]};
      3'd2:    o_data = {32'd0, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22041207_ifu_axi_rd.sv
// Fetch-side AXI4 read master: one request in, one single-beat AR/R transaction,
// right-aligned data back to the fetch stage. One transaction outstanding.
module ysyx_22041207_ifu_axi_rd
  import ysyx_22041207_ifu_axi_rd_pkg::*;
#(
  parameter int AXI_ID = 0,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_r_valid_i,
  output logic              rx_r_ready_o,
  input  logic [ADDR_W-1:0] rx_r_addr_i,
  input  logic [7:0]        rx_r_size_i,
  output logic [63:0]       rx_data_read_o,
  output logic              rx_data_valid,
  input  logic              rx_data_ready,
  output logic              rx_err_o,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);

  localparam logic [ID_W-1:0] W_ID = ID_W'(AXI_ID);

  state_e            r_state;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arsize;
  logic [2:0]        r_off;
  logic              r_rready;
  logic              r_data_valid;
  logic [63:0]       r_data;
  logic              r_err;

  size_dec_t   w_dec;
  logic [63:0] w_aligned;

  assign w_dec = decode_size(rx_r_size_i);

  ysyx_22041207_rd_align u_align (
    .i_rdata  (rdata),
    .i_off    (r_off),
    .i_arsize (r_arsize),
    .o_data   (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arsize     <= 3'd0;
      r_off        <= 3'd0;
      r_rready     <= 1'b0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rx_r_valid_i) begin
            r_off    <= rx_r_addr_i[2:0];
            r_arsize <= w_dec.arsize;
            // An unsupported lane mask never reaches the bus; it is answered locally.
            if (w_dec.illegal) begin
              r_data       <= '0;
              r_err        <= 1'b1;
              r_data_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_araddr  <= rx_r_addr_i;
              r_arvalid <= 1'b1;
              r_state   <= AR;
            end
          end
        end
        AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            r_data       <= w_aligned;
            r_err        <= (rresp != RESP_OKAY) || !rlast || (rid != W_ID);
            r_rready     <= 1'b0;
            r_data_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (rx_data_ready) begin
            r_data_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_r_ready_o   = (r_state == IDLE) && rx_r_valid_i && !rst;
  assign rx_data_read_o = r_data;
  assign rx_data_valid  = r_data_valid;
  assign rx_err_o       = r_err;
  assign arvalid        = r_arvalid;
  assign araddr         = r_araddr;
  assign arid           = W_ID;
  assign arlen          = 8'd0;
  assign arsize         = r_arsize;
  assign arburst        = BURST_INCR;
  assign rready         = r_rready;

endmodule
